// File: rtl/i2c_master_byte.sv
// rtl/i2c_master_byte.sv - byte-level I2C initiator: optional START, one data byte plus ACK, optional STOP
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL while the master has released it.
module i2c_master_byte #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_quarter;
    logic [2:0]    r_bitcnt;
    logic          r_bus_owned;
    logic          r_stop, r_read, r_nack;
    logic [7:0]    r_wdata, r_shift;
    logic          r_ack_in;
    logic          r_rsp_valid, r_rsp_nack;
    logic [7:0]    r_rsp_rdata;

    logic w_accept, w_scl_rel, w_stall, w_qend, w_step_end, w_done;
    logic w_bit_drive, w_ack_drive, w_scl_oe, w_sda_oe;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign w_accept  = cmd_valid & cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_nack  = r_rsp_nack;
    assign scl_oe    = w_scl_oe;
    assign sda_oe    = w_sda_oe;

    // Quarters in which the master lets SCL float high (candidates for slave stretching)
    assign w_scl_rel = ((r_state == S_START || r_state == S_BIT || r_state == S_ACK) &&
                        (r_quarter == 2'd1 || r_quarter == 2'd2)) ||
                       (r_state == S_STOP && r_quarter != 2'd0);

`ifdef I2C_CLK_STRETCH_EN
    assign w_stall = w_scl_rel & ~scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_in;
    assign w_stall      = 1'b0;
`endif

    assign w_qend      = (r_qcnt == Q_LAST) && !w_stall;
    assign w_step_end  = w_qend && (r_quarter == 2'd3);
    assign w_done      = w_step_end && ((r_state == S_ACK && !r_stop) || r_state == S_STOP);
    assign w_bit_drive = ~r_read & ~r_wdata[3'd7 - r_bitcnt];
    assign w_ack_drive = r_read & ~r_nack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl_oe    = 1'b0;
        w_sda_oe    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_scl_oe = r_bus_owned;
                if (w_accept) w_state_nxt = (cmd_start || !r_bus_owned) ? S_START : S_BIT;
            end
            S_START: begin
                case (r_quarter)
                    2'd0:    w_scl_oe = r_bus_owned;
                    2'd1:    w_scl_oe = 1'b0;
                    2'd2:    w_sda_oe = 1'b1;
                    default: begin
                        w_scl_oe = 1'b1;
                        w_sda_oe = 1'b1;
                    end
                endcase
                if (w_step_end) w_state_nxt = S_BIT;
            end
            S_BIT, S_ACK: begin
                w_scl_oe = (r_quarter == 2'd0) || (r_quarter == 2'd3);
                w_sda_oe = (r_state == S_ACK) ? w_ack_drive : w_bit_drive;
                if (w_step_end) begin
                    if (r_state == S_BIT && r_bitcnt == 3'd7) w_state_nxt = S_ACK;
                    else if (r_state == S_ACK)               w_state_nxt = r_stop ? S_STOP : S_IDLE;
                end
            end
            S_STOP: begin
                w_scl_oe = (r_quarter == 2'd0);
                w_sda_oe = (r_quarter == 2'd0) || (r_quarter == 2'd1);
                if (w_step_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_qcnt      <= '0;
            r_quarter   <= 2'd0;
            r_bitcnt    <= 3'd0;
            r_bus_owned <= 1'b0;
            r_stop      <= 1'b0;
            r_read      <= 1'b0;
            r_nack      <= 1'b0;
            r_wdata     <= 8'h00;
            r_shift     <= 8'h00;
            r_ack_in    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_nack  <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_stop    <= cmd_stop;
                r_read    <= cmd_read;
                r_nack    <= cmd_nack;
                r_wdata   <= cmd_wdata;
                r_qcnt    <= '0;
                r_quarter <= 2'd0;
                r_bitcnt  <= 3'd0;
            end else if (r_state != S_IDLE) begin
                if (w_qend) begin
                    r_qcnt    <= '0;
                    r_quarter <= r_quarter + 2'd1;
                end else if (!w_stall) begin
                    r_qcnt <= r_qcnt + 1'b1;
                end
                // Sample SDA on the last clock of the SCL-high window
                if (w_qend && r_quarter == 2'd2) begin
                    if (r_state == S_BIT) r_shift  <= {r_shift[6:0], sda_in};
                    if (r_state == S_ACK) r_ack_in <= sda_in;
                end
                if (w_step_end) begin
                    if (r_state == S_START) r_bus_owned <= 1'b1;
                    if (r_state == S_STOP)  r_bus_owned <= 1'b0;
                    if (r_state == S_BIT)   r_bitcnt    <= r_bitcnt + 3'd1;
                end
                if (w_done) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_nack  <= r_read ? 1'b0 : r_ack_in;
                    if (r_read) r_rsp_rdata <= r_shift;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// tb/tb_i2c_master_byte.sv - randomized self-checking bench with a behavioural I2C slave and transaction model
module tb_i2c_master_byte;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0, cmd_nack = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe, scl_in, sda_in;
    logic [7:0] rsp_rdata;

    logic slave_low = 1'b0, hold = 1'b0;
    wire  scl_line = ~scl_oe;
    wire  sda_line = ~sda_oe & ~slave_low;
    assign scl_in = scl_line & ~hold;
    assign sda_in = sda_line;

    i2c_master_byte #(.CLK_DIV(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_read(cmd_read), .cmd_nack(cmd_nack), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_rsp = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rsp_valid) n_rsp <= n_rsp + 1;

    // Slave-side view of the current command, written only by the stimulus process
    logic [7:0] cur_byte = 8'h00;
    bit cur_read = 0, cur_present = 0, cur_stretch = 0, cur_freeze = 1, cur_expect_start = 0;
    int cmd_seq = 0;

    // Behavioural slave state, written only by the slave process
    int seen_seq = 0, nrise = 0, hold_cnt = 0, n_starts = 0, n_stops = 0;
    bit wait_start = 1, did_stretch = 0;
    logic p_scl = 1'b1, p_msda = 1'b1;
    logic [8:0] rec = '0;

    function automatic logic want(input int n);
        if (cur_read) return (n < 8) ? ~cur_byte[7-n] : 1'b0;
        return (n == 8) ? cur_present : 1'b0;
    endfunction

    always @(negedge clk) begin
        if (seen_seq != cmd_seq) begin
            seen_seq    = cmd_seq;
            nrise       = 0;
            hold        = 1'b0;
            hold_cnt    = 0;
            did_stretch = 0;
            wait_start  = cur_freeze || cur_expect_start;
            slave_low   = wait_start ? 1'b0 : want(0);
        end
        if (scl_line && p_scl && p_msda && sda_oe) begin
            n_starts++;
            wait_start = 0;
            nrise = 0;
        end
        if (scl_line && p_scl && !p_msda && !sda_oe) n_stops++;
        if (!wait_start && scl_line && !p_scl) begin
            if (nrise < 9) rec[nrise] = sda_line;
            nrise++;
        end
        if (!wait_start && !scl_line && p_scl) begin
            slave_low = want(nrise);
            if (cur_stretch && !did_stretch && nrise == 3) begin
                hold = 1'b1;
                did_stretch = 1;
            end
        end
        if (hold && !scl_oe) begin
            hold_cnt++;
            if (hold_cnt == 11) hold = 1'b0;
        end
        p_scl  = scl_line;
        p_msda = ~sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference state
    bit m_owned = 0;
    logic [7:0] m_rdata = 8'h00;

    task automatic do_cmd(input bit st, input bit sp, input bit rd, input bit nk, input logic [7:0] wd,
                          input logic [7:0] sb, input bit present, input bit stretch);
        int s0, p0, acc, extra;
        bit exp_start;
        logic [7:0] got;
        exp_start = st || !m_owned;
        extra = 0;
`ifdef I2C_CLK_STRETCH_EN
        if (stretch) extra = 10;
`endif
        @(negedge clk);
        cur_read = rd; cur_byte = sb; cur_present = present; cur_stretch = stretch;
        cur_freeze = 0; cur_expect_start = exp_start;
        cmd_seq++;
        s0 = n_starts; p0 = n_stops;
        cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; cmd_wdata = wd;
        check("ready_before_accept", cmd_ready, 1);
        acc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("busy_in_transfer", {busy, cmd_ready}, 2'b10);
        while (!rsp_valid && (cyc - acc) < 3000) begin
            @(posedge clk); #1;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        check("latency", cyc - acc, 1 + D * (4 * exp_start + 36 + 4 * sp) + extra);
        check("ready_at_rsp", cmd_ready, 1);
        check("rsp_nack", rsp_nack, rd ? 1'b0 : !present);
        if (rd) m_rdata = sb;
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("start_count", n_starts - s0, exp_start);
        check("stop_count", n_stops - p0, sp);
        if (rd) begin
            check("master_ack_bit", rec[8], nk);
        end else begin
            for (int i = 0; i < 8; i++) got[7-i] = rec[i];
            check("sda_bits", got, wd);
        end
        @(posedge clk); #1;
        check("rsp_pulse_len", rsp_valid, 0);
        check("idle_scl_oe", scl_oe, !sp);
        check("idle_sda_oe", sda_oe, 0);
        m_owned = !sp;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int r0, guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {scl_oe, sda_oe}, 2'b00);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_nack", rsp_nack, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        do_cmd(1, 0, 0, 0, 8'hA0, 8'h00, 1, 0);
        do_cmd(0, 1, 1, 1, 8'h00, 8'h5A, 1, 0);
        do_cmd(1, 1, 0, 0, 8'hAE, 8'h00, 0, 0);
        do_cmd(1, 0, 0, 0, 8'h3C, 8'h00, 1, 1);
        do_cmd(0, 1, 1, 0, 8'h00, 8'hC3, 1, 0);

        // Reset pulsed in the middle of bit 5
        @(negedge clk);
        cur_read = 0; cur_byte = 8'h00; cur_present = 1; cur_stretch = 0;
        cur_freeze = 0; cur_expect_start = 1;
        cmd_seq++;
        cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_wdata = 8'h55;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (nrise < 6 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("reach_bit5", nrise >= 6, 1);
        @(negedge clk);
        r0 = n_rsp;
        reset_n = 1'b0;
        #1;
        check("rst_mid_oe", {scl_oe, sda_oe}, 2'b00);
        check("rst_mid_ready", cmd_ready, 1);
        cur_freeze = 1;
        cmd_seq++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid_no_rsp", n_rsp - r0, 0);
        m_owned = 0;
        m_rdata = 8'h00;
        do_cmd(0, 0, 0, 0, 8'h96, 8'h00, 1, 0);

        for (int i = 0; i < 12; i++) begin
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
